// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB types and constants for the response mux slice
//
// Contents:
//   htrans_t     - manager transfer type encoding
//   HRESP_OKAY   - response code for OKAY
//   HRESP_ERROR  - response code for ERROR
//   resp_state_t - default-subordinate error FSM states
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        OK   = 2'b00,
        ERR1 = 2'b01,
        ERR2 = 2'b10
    } resp_state_t;

endpackage

// File: rtl/ahb_default_sub.sv
// rtl/ahb_default_sub.sv - default subordinate: two-cycle ERROR FSM and optional stall timeout
//
// Optional feature macro: AHB_RESP_MUX_TIMEOUT_EN (stall timeout counter)
//
// Ports:
//   clk            - system clock
//   reset          - asynchronous active-high reset
//   hready_i       - muxed bus HREADY (address phase accepted when 1)
//   hsel_default_i - active transfer with no decoder select
//   sub_stall_i    - selected subordinate is driving HREADYOUT low
//   hreadyout_o    - default subordinate HREADYOUT
//   hresp_o        - default subordinate HRESP
//   active_o       - FSM owns the data phase (ERR1 or ERR2)
//   timeout_o      - stall limit hit; the mux drops its registered select
module ahb_default_sub
    import ahb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic hready_i,
    input  logic hsel_default_i,
    input  logic sub_stall_i,
    output logic hreadyout_o,
    output logic hresp_o,
    output logic active_o,
    output logic timeout_o
);

    resp_state_t state_q, state_d;

`ifdef AHB_RESP_MUX_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CYCLES = 8'd255;

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (hready_i) begin
            cnt_d = '0;
        end else if (sub_stall_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Fires on the last of TIMEOUT_CYCLES stall cycles so the error
    // response begins on the very next cycle.
    assign timeout_o = sub_stall_i && (cnt_q == TIMEOUT_CYCLES - 8'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_stall;
    assign unused_stall = sub_stall_i;
    assign timeout_o    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            OK: begin
                if (hready_i && hsel_default_i) begin
                    state_d = ERR1;
                end
            end
            ERR1: begin
                state_d = ERR2;
            end
            ERR2: begin
                // ERR2 is an HREADY=1 cycle, so it also accepts the next address phase.
                state_d = hsel_default_i ? ERR1 : OK;
            end
            default: begin
                state_d = OK;
            end
        endcase
        if (timeout_o) begin
            state_d = ERR1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= OK;
        end else begin
            state_q <= state_d;
        end
    end

    assign active_o    = (state_q != OK);
    assign hreadyout_o = (state_q != ERR1);
    assign hresp_o     = active_o ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/ahb_resp_mux.sv
// rtl/ahb_resp_mux.sv - AHB data-phase response mux with built-in default subordinate
//
// Optional feature macro: AHB_RESP_MUX_TIMEOUT_EN (stall timeout in ahb_default_sub)
//
// Ports:
//   clk          - system clock
//   reset        - asynchronous active-high reset
//   HSELVec      - address-phase one-hot selects from decoders
//   HTRANS       - manager transfer type
//   HRDATAVec    - subordinate read data, slice i = subordinate i
//   HREADYOUTVec - subordinate ready outputs
//   HRESPVec     - subordinate responses
//   HRDATA       - muxed read data
//   HREADY       - muxed ready, also the HREADY input of every subordinate
//   HRESP        - muxed response
//   MultiSel     - sticky overlapping-decode flag
//   HSELDefault  - active transfer that no decoder claims
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter int NSUB = 8,
    parameter int XLEN = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSUB-1:0]      HSELVec,
    input  logic [1:0]           HTRANS,
    input  logic [NSUB*XLEN-1:0] HRDATAVec,
    input  logic [NSUB-1:0]      HREADYOUTVec,
    input  logic [NSUB-1:0]      HRESPVec,
    output logic [XLEN-1:0]      HRDATA,
    output logic                 HREADY,
    output logic                 HRESP,
    output logic                 MultiSel,
    output logic                 HSELDefault
);

    htrans_t         htrans;
    logic            trans_active;
    logic [NSUB-1:0] sel_req;
    logic [NSUB-1:0] sel_low;
    logic            sel_multi;
    logic [NSUB-1:0] sel_q, sel_d;
    logic            multi_q, multi_d;
    logic            sub_stall;
    logic            def_hready;
    logic            def_hresp;
    logic            def_active;
    logic            def_timeout;

    assign htrans       = htrans_t'(HTRANS);
    assign trans_active = (htrans == NONSEQ) || (htrans == SEQ);

    // IDLE/BUSY mask the selects so they can neither claim a subordinate nor error.
    assign sel_req     = HSELVec & {NSUB{trans_active}};
    // Two's-complement trick isolates the lowest set bit; clearing it
    // leaves something only when more than one decoder claimed the transfer.
    assign sel_low     = sel_req & (~sel_req + NSUB'(1));
    assign sel_multi   = |(sel_req & (sel_req - NSUB'(1)));
    assign HSELDefault = trans_active & ~(|HSELVec);

    assign sub_stall = ~def_active & (|(sel_q & ~HREADYOUTVec));

    ahb_default_sub u_default_sub (
        .clk            (clk),
        .reset          (reset),
        .hready_i       (HREADY),
        .hsel_default_i (HSELDefault),
        .sub_stall_i    (sub_stall),
        .hreadyout_o    (def_hready),
        .hresp_o        (def_hresp),
        .active_o       (def_active),
        .timeout_o      (def_timeout)
    );

    always_comb begin
        sel_d   = sel_q;
        multi_d = multi_q;
        if (def_timeout) begin
            sel_d = '0;
        end else if (HREADY) begin
            sel_d   = sel_low;
            multi_d = multi_q | sel_multi;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q   <= '0;
            multi_q <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            multi_q <= multi_d;
        end
    end

    assign MultiSel = multi_q;

    // No registered select and no error in progress means an idle/busy
    // data phase, answered as a zero-wait OKAY.
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        if (def_active) begin
            HREADY = def_hready;
            HRESP  = def_hresp;
        end else begin
            for (int i = 0; i < NSUB; i++) begin
                if (sel_q[i]) begin
                    HRDATA = HRDATAVec[i*XLEN +: XLEN];
                    HREADY = HREADYOUTVec[i];
                    HRESP  = HRESPVec[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// tb/tb_ahb_resp_mux.sv - scoreboard testbench for ahb_resp_mux
module tb_ahb_resp_mux;

    localparam int NSUB = 8;
    localparam int XLEN = 64;
    localparam logic [1:0] TI = 2'b00;
    localparam logic [1:0] TB = 2'b01;
    localparam logic [1:0] TN = 2'b10;
    localparam logic [1:0] TS = 2'b11;
    localparam logic [7:0] ALL = 8'hFF;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NSUB-1:0]      HSELVec;
    logic [1:0]           HTRANS;
    logic [NSUB*XLEN-1:0] HRDATAVec;
    logic [NSUB-1:0]      HREADYOUTVec;
    logic [NSUB-1:0]      HRESPVec;
    logic [XLEN-1:0]      HRDATA;
    logic                 HREADY;
    logic                 HRESP;
    logic                 MultiSel;
    logic                 HSELDefault;

    typedef struct {
        logic        rdy;
        logic        resp;
        logic [63:0] data;
        logic        multi;
        logic        hdef;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    ahb_resp_mux #(.NSUB(NSUB), .XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .HSELVec      (HSELVec),
        .HTRANS       (HTRANS),
        .HRDATAVec    (HRDATAVec),
        .HREADYOUTVec (HREADYOUTVec),
        .HRESPVec     (HRESPVec),
        .HRDATA       (HRDATA),
        .HREADY       (HREADY),
        .HRESP        (HRESP),
        .MultiSel     (MultiSel),
        .HSELDefault  (HSELDefault)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] dv(input int i);
        return {32'hDEADBEEF, 32'(i)};
    endfunction

    // Inputs for one cycle plus the outputs expected during that same cycle.
    task automatic drive(input string nm, input logic [7:0] sel, input logic [1:0] tr,
                         input logic [7:0] rdyv, input logic [7:0] respv,
                         input logic er, input logic es, input logic [63:0] ed,
                         input logic em, input logic eh);
        exp_t e;
        HSELVec      = sel;
        HTRANS       = tr;
        HREADYOUTVec = rdyv;
        HRESPVec     = respv;
        e.rdy   = er;
        e.resp  = es;
        e.data  = ed;
        e.multi = em;
        e.hdef  = eh;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step(input string nm, input logic [7:0] sel, input logic [1:0] tr,
                        input logic [7:0] rdyv, input logic [7:0] respv,
                        input logic er, input logic es, input logic [63:0] ed,
                        input logic em, input logic eh);
        drive(nm, sel, tr, rdyv, respv, er, es, ed, em, eh);
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are valid every cycle; compare at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if ({HREADY, HRESP, HRDATA, MultiSel, HSELDefault} !==
                {e.rdy, e.resp, e.data, e.multi, e.hdef}) begin
                errors++;
                $display("FAIL %s got rdy=%b resp=%b data=%h multi=%b hdef=%b exp rdy=%b resp=%b data=%h multi=%b hdef=%b",
                         nm, HREADY, HRESP, HRDATA, MultiSel, HSELDefault,
                         e.rdy, e.resp, e.data, e.multi, e.hdef);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        HSELVec      = '0;
        HTRANS       = TI;
        HREADYOUTVec = ALL;
        HRESPVec     = '0;
        for (int i = 0; i < NSUB; i++) begin
            HRDATAVec[i*XLEN +: XLEN] = dv(i);
        end
        @(posedge clk);
        #1;

        step("rst_state",   8'h00, TI, ALL, 8'h00, 1, 0, 64'h0, 0, 0);
        reset = 1'b0;
        step("idle",        8'h00, TI, ALL, 8'h00, 1, 0, 64'h0, 0, 0);

        // Claimed read from sub2
        step("sub2_addr",   8'h04, TN, ALL, 8'h00, 1, 0, 64'h0, 0, 0);
        step("sub2_data",   8'h00, TI, ALL, 8'h00, 1, 0, dv(2), 0, 0);

        // Unclaimed, then back-to-back unclaimed during ERR2
        step("dflt_addr",   8'h00, TN, ALL, 8'h00, 1, 0, 64'h0, 0, 1);
        step("dflt_err1",   8'h00, TI, ALL, 8'h00, 0, 1, 64'h0, 0, 0);
        step("dflt_err2_b2b", 8'h00, TN, ALL, 8'h00, 1, 1, 64'h0, 0, 1);
        step("b2b_err1",    8'h00, TI, ALL, 8'h00, 0, 1, 64'h0, 0, 0);
        step("b2b_err2",    8'h00, TI, ALL, 8'h00, 1, 1, 64'h0, 0, 0);
        step("err_to_ok",   8'h00, TI, ALL, 8'h00, 1, 0, 64'h0, 0, 0);

        // Sub5 with three wait states; select presented during waits is ignored
        step("sub5_addr",   8'h20, TN, ALL, 8'h00, 1, 0, 64'h0, 0, 0);
        step("sub5_wait1",  8'h04, TN, 8'hDF, 8'h00, 0, 0, dv(5), 0, 0);
        step("sub5_wait2",  8'h04, TN, 8'hDF, 8'h00, 0, 0, dv(5), 0, 0);
        step("sub5_wait3",  8'h04, TN, 8'hDF, 8'h00, 0, 0, dv(5), 0, 0);
        step("sub5_done",   8'h02, TN, ALL, 8'h00, 1, 0, dv(5), 0, 0);
        step("sub1_after",  8'h00, TI, ALL, 8'h00, 1, 0, dv(1), 0, 0);

        // BUSY never selects nor errors
        step("busy_sel",    8'h04, TB, ALL, 8'h00, 1, 0, 64'h0, 0, 0);
        step("busy_nosel",  8'h00, TB, ALL, 8'h00, 1, 0, 64'h0, 0, 0);
        step("busy_after",  8'h00, TI, ALL, 8'h00, 1, 0, 64'h0, 0, 0);

        // Subordinate ERROR passthrough on SEQ
        step("sub6_addr",   8'h40, TS, ALL, 8'h00, 1, 0, 64'h0, 0, 0);
        step("sub6_err",    8'h00, TI, ALL, 8'h40, 1, 1, dv(6), 0, 0);
        step("sub6_after",  8'h00, TI, ALL, 8'h00, 1, 0, 64'h0, 0, 0);

        // Overlapping decode: lowest index wins, MultiSel sticks
        step("multi_addr",  8'h12, TN, ALL, 8'h00, 1, 0, 64'h0, 0, 0);
        step("multi_sub1",  8'h08, TN, ALL, 8'h00, 1, 0, dv(1), 1, 0);
        step("clean_sub3",  8'h00, TI, ALL, 8'h00, 1, 0, dv(3), 1, 0);
        step("multi_sticky", 8'h00, TI, ALL, 8'h00, 1, 0, 64'h0, 1, 0);

        // Reset asserted while in ERR1
        step("pre_rst_addr", 8'h00, TN, ALL, 8'h00, 1, 0, 64'h0, 1, 1);
        drive("pre_rst_err1", 8'h00, TI, ALL, 8'h00, 0, 1, 64'h0, 1, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("rst_held",    8'h00, TI, ALL, 8'h00, 1, 0, 64'h0, 0, 0);
        reset = 1'b0;
        step("post_rst",    8'h00, TI, ALL, 8'h00, 1, 0, 64'h0, 0, 0);

        // Sub3 stuck not-ready
        step("stuck_addr",  8'h08, TN, ALL, 8'h00, 1, 0, 64'h0, 0, 0);
`ifdef AHB_RESP_MUX_TIMEOUT_EN
        for (int k = 0; k < 255; k++) begin
            step("stuck_wait", 8'h00, TI, 8'hF7, 8'h00, 0, 0, dv(3), 0, 0);
        end
        step("timeout_err1", 8'h00, TI, 8'hF7, 8'h00, 0, 1, 64'h0, 0, 0);
        step("timeout_err2", 8'h00, TI, 8'hF7, 8'h00, 1, 1, 64'h0, 0, 0);
        step("timeout_ok",   8'h00, TI, ALL, 8'h00, 1, 0, 64'h0, 0, 0);
`else
        for (int k = 0; k < 300; k++) begin
            step("stuck_wait", 8'h00, TI, 8'hF7, 8'h00, 0, 0, dv(3), 0, 0);
        end
        step("stuck_release", 8'h00, TI, ALL, 8'h00, 1, 0, dv(3), 0, 0);
        step("stuck_ok",      8'h00, TI, ALL, 8'h00, 1, 0, 64'h0, 0, 0);
`endif

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_resp_mux.md
Name: ahb_resp_mux

Overview:
- Data-phase counterpart of the per-peripheral address decoders in the uncore.
- Decoders assert one Sel per subordinate during the AHB address phase. This block registers that selection into the data phase.
- It muxes the chosen subordinate's HRDATA, HREADYOUT and HRESP back to the manager.
- It acts as the default subordinate: any active transfer that no decoder claims gets a two-cycle AHB ERROR response. Unclaimed transfers include unsupported, wrong-size and invalid-access cases, because those gate Sel.

Parameters:
- NSUB, 8, number of subordinates / decoder Sel lines
- XLEN, 64, data width

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- HSELVec  input  NSUB  address-phase one-hot select from decoders (bit i = subordinate i)
- HTRANS  input  2  manager transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HRDATAVec  input  NSUB*XLEN  subordinate read data; slice i = subordinate i
- HREADYOUTVec  input  NSUB  subordinate ready outputs
- HRESPVec  input  NSUB  subordinate responses (1 = ERROR)
- HRDATA  output  XLEN  muxed read data to manager
- HREADY  output  1  muxed ready; also fed back to every subordinate as HREADY in
- HRESP  output  1  muxed response
- MultiSel  output  1  sticky flag: overlapping decode observed
- HSELDefault  output  1  address-phase indicator: active transfer with no select

Behaviour:
- Clock and reset are decided: one clock (clk); reset asynchronous, active-high (reset).
- Active transfer: HTRANS[1]=1.
- Address-phase sample: on each clk rising edge with HREADY=1, register SelD <= HSELVec & {NSUB{HTRANS[1]}}.
  - If more than one bit is set, keep only the lowest index and set MultiSel. MultiSel clears only on reset.
- HSELDefault = HTRANS[1] & ~|HSELVec (combinational).
- Default-subordinate FSM, states OK, ERR1, ERR2:
  - OK -> ERR1 when HREADY=1 and HSELDefault=1.
  - ERR1 -> ERR2 unconditionally. Outputs in ERR1: HREADY=0, HRESP=1.
  - ERR2 outputs HREADY=1, HRESP=1.
  - ERR2 -> ERR1 when HSELDefault=1; otherwise ERR2 -> OK.
  - ERR2 samples the next address phase like any HREADY=1 cycle.
- Data-phase mux (combinational from SelD and FSM):
  - FSM in ERR1/ERR2: error outputs above; HRDATA=0.
  - SelD one-hot i: HRDATA=slice i, HREADY=HREADYOUTVec[i], HRESP=HRESPVec[i].
  - SelD=0 and FSM=OK (idle/busy data phase): HREADY=1, HRESP=0, HRDATA=0 (zero-wait OKAY).
- Wait states: while HREADY=0, SelD and FSM hold. A new address phase is not sampled.
- Latency: zero added cycles for claimed transfers. Unclaimed transfers take exactly 2 data-phase cycles.
- Reset values: SelD=0, FSM=OK, MultiSel=0. Outputs HREADY=1, HRESP=0, HRDATA=0.
- Reset mid-transfer: immediate return to the reset values above. In-flight data phase is discarded.
- BUSY and IDLE never select a subordinate and never cause an error.

Optional Feature:
- Macro AHB_RESP_MUX_TIMEOUT_EN, with local parameter TIMEOUT_CYCLES=255 (8-bit counter).
- Defined:
  - Counter increments each cycle that a selected subordinate drives HREADYOUT=0.
  - Counter clears whenever HREADY=1.
  - When it reaches TIMEOUT_CYCLES, FSM is forced to ERR1, overriding the subordinate, and SelD clears. This produces the standard two-cycle ERROR.
  - The subordinate is assumed to drop the transfer on HREADY.
- Undefined: no counter; a stalled subordinate stalls the bus indefinitely.

Decomposition:
- Shared package ahb_pkg:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ)
  - HRESP_OKAY/HRESP_ERROR constants
  - resp_state_t enum (OK, ERR1, ERR2)
- One natural sub-module, ahb_default_sub: the error FSM plus optional timeout counter. Outputs its own HREADYOUT/HRESP and an active flag to the mux.

Test Plan:
- Reset asserted mid-ERR1 -> next cycle HREADY=1, HRESP=0, HRDATA=0, SelD=0.
- NONSEQ with HSELVec=8'b0000_0100, sub2 HRDATA=0xDEADBEEF_00000002, HREADYOUT=1 -> following cycle HRDATA=0xDEADBEEF_00000002, HREADY=1, HRESP=0.
- NONSEQ with HSELVec=0 -> data cycle 1 HREADY=0/HRESP=1, cycle 2 HREADY=1/HRESP=1, then OK. A back-to-back unclaimed NONSEQ in ERR2 -> ERR1 again.
- Sub5 selected, HREADYOUT low 3 cycles -> HREADY=0 for 3 cycles, SelD held, new HSELVec ignored, 4th cycle completes.
- HSELVec=8'b0001_0010 -> sub1 routed, MultiSel=1 and stays 1 after later clean transfers.
- With AHB_RESP_MUX_TIMEOUT_EN, sub3 HREADYOUT stuck 0 -> after 255 stall cycles, ERR1 then ERR2 with HRESP=1. Without the macro, HREADY stays 0.
